// File: rtl/alg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alg_seq_ctrl
//
// Sequencing controller for the 4-bit combinational ALU `alg`. It collects
// operand A, an operator and operand B from single-cycle keypad strobes. It
// holds them on the ALU inputs, waits EXEC_WAIT cycles for the ALU to settle,
// then captures the full-width result for the display path. It also counts
// completed operations.
//
// Optional feature macro: ALG_CHAIN_EN
//   Defined   : op_valid in S_SHOW loads the low DW bits of the result into
//               operand A, takes the new operator, clears B and moves to S_B,
//               so calculations can be chained.
//   Undefined : op_valid in S_SHOW is ignored.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   clr          in   synchronous user clear (keeps op_count)
//   digit_valid  in   digit strobe
//   digit_in     in   [DW-1:0] digit value
//   op_valid     in   operator strobe
//   op_in        in   [OPW-1:0] operator code
//   eq_valid     in   "=" strobe
//   alu_a        out  [DW-1:0] registered operand A to alg.a
//   alu_b        out  [DW-1:0] registered operand B to alg.b
//   alu_op       out  [OPW-1:0] registered operator to alg.op
//   alu_out      in   [RW-1:0] result from alg.out
//   result       out  [RW-1:0] captured result, held until the next capture
//   result_valid out  one-cycle pulse when result is updated
//   busy         out  high while in S_EXEC
//   state_o      out  [1:0] current state encoding
//   op_count     out  [7:0] completed-operation counter (wraps)
// -----------------------------------------------------------------------------
module alg_seq_ctrl #(
    parameter int DW        = 4,
    parameter int OPW       = 3,
    parameter int RW        = 8,
    parameter int EXEC_WAIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           digit_valid,
    input  logic [DW-1:0]  digit_in,
    input  logic           op_valid,
    input  logic [OPW-1:0] op_in,
    input  logic           eq_valid,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [RW-1:0]  alu_out,
    output logic [RW-1:0]  result,
    output logic           result_valid,
    output logic           busy,
    output logic [1:0]     state_o,
    output logic [7:0]     op_count
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Four bits cover the legal EXEC_WAIT range of 1..15.
    localparam int CW = 4;
    localparam logic [CW-1:0] WAIT_LAST = CW'(EXEC_WAIT - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  wait_cnt, wait_nxt;
    logic [DW-1:0]  alu_a_nxt, alu_b_nxt;
    logic [OPW-1:0] alu_op_nxt;
    logic [RW-1:0]  result_nxt;
    logic           result_valid_nxt;
    logic [7:0]     op_count_nxt;

    assign busy    = (state == S_EXEC);
    assign state_o = state;

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt        = state;
        wait_nxt         = wait_cnt;
        alu_a_nxt        = alu_a;
        alu_b_nxt        = alu_b;
        alu_op_nxt       = alu_op;
        result_nxt       = result;
        result_valid_nxt = 1'b0;
        op_count_nxt     = op_count;

        if (clr) begin
            // The user clear wins over every strobe, even mid-execution.
            state_nxt  = S_A;
            wait_nxt   = '0;
            alu_a_nxt  = '0;
            alu_b_nxt  = '0;
            alu_op_nxt = '0;
            result_nxt = '0;
        end else begin
            // Within each state the strobes are tested in priority order
            // eq > op > digit, skipping any that the state does not accept.
            unique case (state)
                S_A: begin
                    if (op_valid) begin
                        alu_op_nxt = op_in;
                        state_nxt  = S_B;
                    end else if (digit_valid) begin
                        alu_a_nxt = digit_in;
                    end
                end
                S_B: begin
                    if (eq_valid) begin
                        wait_nxt  = '0;
                        state_nxt = S_EXEC;
                    end else if (op_valid) begin
                        alu_op_nxt = op_in;
                    end else if (digit_valid) begin
                        alu_b_nxt = digit_in;
                    end
                end
                S_EXEC: begin
                    // Operands are frozen here so the ALU sees stable inputs
                    // for the whole settle window.
                    if (wait_cnt == WAIT_LAST) begin
                        result_nxt       = alu_out;
                        result_valid_nxt = 1'b1;
                        op_count_nxt     = op_count + 8'd1;
                        wait_nxt         = '0;
                        state_nxt        = S_SHOW;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (eq_valid) begin
                        wait_nxt  = '0;
                        state_nxt = S_EXEC;
`ifdef ALG_CHAIN_EN
                    end else if (op_valid) begin
                        alu_a_nxt  = result[DW-1:0];
                        alu_b_nxt  = '0;
                        alu_op_nxt = op_in;
                        state_nxt  = S_B;
`endif
                    end else if (digit_valid) begin
                        alu_a_nxt = digit_in;
                        alu_b_nxt = '0;
                        state_nxt = S_A;
                    end
                end
                default: state_nxt = S_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_A;
            wait_cnt     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            op_count     <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            alu_a        <= alu_a_nxt;
            alu_b        <= alu_b_nxt;
            alu_op       <= alu_op_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            op_count     <= op_count_nxt;
        end
    end

endmodule

// File: tb/tb_alg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alg_seq_ctrl
//
// Two controller instances: u0 with EXEC_WAIT=1 and u1 with EXEC_WAIT=4. Each
// drives a stand-in ALU model. Expected results, together with the cycle on
// which they must appear, are queued when "=" is issued. A monitor per
// instance pops and compares them whenever result_valid is seen.
// Stand-in ALU: 0 add, 1 mul, 2 sub, 3 {a,b}, 4 and, 5 or, 6 xor, 7 ~a.
// -----------------------------------------------------------------------------
module tb_alg_seq_ctrl;

    typedef struct {
        logic [7:0] res;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Instance 0 (EXEC_WAIT=1)
    logic       clr0 = 0, dv0 = 0, ov0 = 0, ev0 = 0;
    logic [3:0] d0 = 0;
    logic [2:0] o0 = 0;
    logic [3:0] a0, b0;
    logic [2:0] op0;
    logic [7:0] alu0, res0, cnt0;
    logic       rv0, busy0;
    logic [1:0] st0;

    // Instance 1 (EXEC_WAIT=4)
    logic       clr1 = 0, dv1 = 0, ov1 = 0, ev1 = 0;
    logic [3:0] d1 = 0;
    logic [2:0] o1 = 0;
    logic [3:0] a1, b1;
    logic [2:0] op1;
    logic [7:0] alu1, res1, cnt1;
    logic       rv1, busy1;
    logic [1:0] st1;

    function automatic logic [7:0] alg(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
        case (op)
            3'd0:    return {4'b0, a} + {4'b0, b};
            3'd1:    return {4'b0, a} * {4'b0, b};
            3'd2:    return {4'b0, a} - {4'b0, b};
            3'd3:    return {a, b};
            3'd4:    return {4'b0, a & b};
            3'd5:    return {4'b0, a | b};
            3'd6:    return {4'b0, a ^ b};
            default: return {4'b0, ~a};
        endcase
    endfunction

    assign alu0 = alg(a0, b0, op0);
    assign alu1 = alg(a1, b1, op1);

    alg_seq_ctrl #(.DW(4), .OPW(3), .RW(8), .EXEC_WAIT(1)) u0 (
        .clk(clk), .rst(rst), .clr(clr0),
        .digit_valid(dv0), .digit_in(d0), .op_valid(ov0), .op_in(o0),
        .eq_valid(ev0), .alu_a(a0), .alu_b(b0), .alu_op(op0),
        .alu_out(alu0), .result(res0), .result_valid(rv0), .busy(busy0),
        .state_o(st0), .op_count(cnt0)
    );

    alg_seq_ctrl #(.DW(4), .OPW(3), .RW(8), .EXEC_WAIT(4)) u1 (
        .clk(clk), .rst(rst), .clr(clr1),
        .digit_valid(dv1), .digit_in(d1), .op_valid(ov1), .op_in(o1),
        .eq_valid(ev1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
        .alu_out(alu1), .result(res1), .result_valid(rv1), .busy(busy1),
        .state_o(st1), .op_count(cnt1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus on instance `which`; returns #1 after the edge.
    // When `push` is set, the expected result and its due cycle are queued.
    task automatic step(input int which, input logic dv, input logic [3:0] d,
                        input logic ov, input logic [2:0] o, input logic ev,
                        input logic cl, input logic push, input logic [7:0] exp);
        exp_t e;
        @(negedge clk);
        if (which == 0) begin
            dv0 = dv; d0 = d; ov0 = ov; o0 = o; ev0 = ev; clr0 = cl;
        end else begin
            dv1 = dv; d1 = d; ov1 = ov; o1 = o; ev1 = ev; clr1 = cl;
        end
        if (ev && push) begin
            e.res = exp;
            e.due = cyc + 1 + ((which == 0) ? 1 : 4);
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        dv0 = 0; ov0 = 0; ev0 = 0; clr0 = 0;
        dv1 = 0; ov1 = 0; ev1 = 0; clr1 = 0;
    endtask

    task automatic dig(input int w, input logic [3:0] d);
        step(w, 1, d, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic opk(input int w, input logic [2:0] o);
        step(w, 0, 0, 1, o, 0, 0, 0, 0);
    endtask
    task automatic eq(input int w, input logic push, input logic [7:0] exp);
        step(w, 0, 0, 0, 0, 1, 0, push, exp);
    endtask
    task automatic idle(input int w);
        step(w, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk0(input string tag, input logic [1:0] st, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] op);
        check({tag, ".state"}, st0, st);
        check({tag, ".alu_a"}, a0, a);
        check({tag, ".alu_b"}, b0, b);
        check({tag, ".alu_op"}, op0, op);
    endtask

    // Scoreboard monitors: compare value and arrival cycle on each pulse.
    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL u0.unexpected_result: got %0h at cycle %0d, expected none", res0, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0.result", res0, e.res);
                check("u0.latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rv1) begin
            if (q1.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL u1.unexpected_result: got %0h at cycle %0d, expected none", res1, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1.result", res1, e.res);
                check("u1.latency", cyc, e.due);
            end
        end
    end

    initial begin
        // Reset
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk0("rst", 0, 0, 0, 0);
        check("rst.result", res0, 0);
        check("rst.rv", rv0, 0);
        check("rst.busy", busy0, 0);
        check("rst.count", cnt0, 0);
        check("rst.u1.state", st1, 0);
        @(negedge clk);
        rst = 0;

        // Basic operation: 1 * 2
        dig(0, 1);   chk0("t1.dig1", 0, 1, 0, 0);
        opk(0, 1);   chk0("t1.op", 1, 1, 0, 1);
        dig(0, 2);   chk0("t1.dig2", 1, 1, 2, 1);
        eq(0, 1, 8'h02);
        chk0("t1.exec", 2, 1, 2, 1);
        check("t1.busy", busy0, 1);
        idle(0);
        check("t1.state", st0, 3);
        check("t1.rv", rv0, 1);
        check("t1.busy_low", busy0, 0);
        check("t1.res", res0, 8'h02);
        check("t1.count", cnt0, 1);
        idle(0);
        check("t1.rv_one_cycle", rv0, 0);

        // Overwrite and priority: {12,11} concat
        dig(0, 4);   chk0("t2.dig4", 0, 4, 0, 1);
        dig(0, 12);  chk0("t2.dig12", 0, 12, 0, 1);
        opk(0, 2);   chk0("t2.op", 1, 12, 0, 2);
        dig(0, 11);  chk0("t2.dig11", 1, 12, 11, 2);
        step(0, 1, 5, 1, 3, 0, 0, 0, 0);
        chk0("t2.op_beats_digit", 1, 12, 11, 3);
        eq(0, 1, 8'hCB);
        idle(0);
        check("t2.res", res0, 8'hCB);
        check("t2.count", cnt0, 2);

        // Repeat and new calculation
        eq(0, 1, 8'hCB);
        check("t4.exec", st0, 2);
        idle(0);
        check("t4.state", st0, 3);
        check("t4.count", cnt0, 3);
        dig(0, 7);   chk0("t4.newcalc", 0, 7, 0, 3);
        eq(0, 0, 0); chk0("t4.eq_in_A_ignored", 0, 7, 0, 3);

        // Chaining from result 8'h1F
        dig(0, 1);
        opk(0, 3);
        dig(0, 15);
        eq(0, 1, 8'h1F);
        idle(0);
        check("t5.res", res0, 8'h1F);
        opk(0, 0);
`ifdef ALG_CHAIN_EN
        chk0("t5.chain", 1, 4'hF, 0, 0);
`else
        chk0("t5.nochain", 3, 1, 15, 3);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk0("t5.clr", 0, 0, 0, 0);
        check("t5.clr.res", res0, 0);
        check("t5.clr.count", cnt0, 4);

        // Long settle window, strobes ignored while busy
        dig(1, 3);
        opk(1, 0);
        dig(1, 4);
        eq(1, 1, 8'h07);
        dig(1, 9);
        check("u1.exec.dig_ignored", a1, 3);
        opk(1, 5);
        check("u1.exec.op_ignored", op1, 0);
        idle(1);
        check("u1.exec.busy", busy1, 1);
        check("u1.exec.state", st1, 2);
        idle(1);
        check("u1.show.state", st1, 3);
        check("u1.show.res", res1, 8'h07);
        check("u1.show.count", cnt1, 1);

        // Clear mid-operation: no capture, counter kept
        eq(1, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("t3.state", st1, 0);
        check("t3.alu_a", a1, 0);
        check("t3.alu_b", b1, 0);
        check("t3.alu_op", op1, 0);
        check("t3.res", res1, 0);
        check("t3.busy", busy1, 0);
        repeat (6) idle(1);
        check("t3.count", cnt1, 1);
        check("t3.state_after", st1, 0);
        dig(1, 1);
        opk(1, 1);
        dig(1, 5);
        eq(1, 1, 8'h05);
        repeat (4) idle(1);
        check("t3.after.res", res1, 8'h05);
        check("t3.after.count", cnt1, 2);

        // Counter wrap: count is 4 here, 252 more ops reach 256
        dig(0, 2);
        opk(0, 0);
        dig(0, 3);
        eq(0, 1, 8'h05);
        idle(0);
        check("t6.count5", cnt0, 5);
        for (int i = 0; i < 250; i++) begin
            eq(0, 1, 8'h05);
            idle(0);
        end
        check("t6.count255", cnt0, 255);
        eq(0, 1, 8'h05);
        idle(0);
        check("t6.wrap", cnt0, 0);
        eq(0, 1, 8'h05);
        idle(0);
        check("t6.count1", cnt0, 1);

        // Reset beats a simultaneous eq strobe
        @(negedge clk);
        rst = 1;
        ev0 = 1;
        @(posedge clk);
        #1;
        rst = 0;
        ev0 = 0;
        chk0("t6.rst", 0, 0, 0, 0);
        check("t6.rst.res", res0, 0);
        check("t6.rst.rv", rv0, 0);
        check("t6.rst.busy", busy0, 0);
        check("t6.rst.count", cnt0, 0);

        // Drain bound: every queued result must have arrived
        repeat (10) @(posedge clk);
        check("u0.queue_drained", q0.size(), 0);
        check("u1.queue_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
